// File: rtl/bcd_range_counter.sv
// Multi-digit BCD counter over an inclusive decimal range MIN_VALUE..MAX_VALUE,
// with up/down stepping, validated synchronous load and cascadable carry/borrow.
module bcd_range_counter #(
    parameter int DIGITS    = 2,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = 23
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  CEN,
    input  logic                  INC,
    input  logic                  DEC,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] res;
        int           r;
        res = '0;
        r   = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VALUE);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    generate
        if (DIGITS < 1 || DIGITS > 4 || MIN_VALUE < 0 || MIN_VALUE >= MAX_VALUE ||
            MAX_VALUE > 10**DIGITS - 1) begin : g_bad_params
            $error("bcd_range_counter: illegal DIGITS/MIN_VALUE/MAX_VALUE combination");
        end
    endgenerate

    logic [W-1:0]      count_q, count_d;
    logic              load_err_q, load_err_d;
    logic [W-1:0]      inc_val, dec_val;
    logic [DIGITS-1:0] inc_c, dec_b, digit_ok;
    logic              above_min, load_ok;
    logic              up, dn, at_max, at_min;

    // Ripple +1/-1 through the digits; a digit only moves when every lower digit wraps.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            assign d = count_q[4*gi +: 4];
            if (gi == 0) begin : g_first
                assign inc_c[gi] = 1'b1;
                assign dec_b[gi] = 1'b1;
            end else begin : g_rest
                assign inc_c[gi] = inc_c[gi-1] & (count_q[4*(gi-1) +: 4] == 4'd9);
                assign dec_b[gi] = dec_b[gi-1] & (count_q[4*(gi-1) +: 4] == 4'd0);
            end
            assign inc_val[4*gi +: 4] = !inc_c[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign dec_val[4*gi +: 4] = !dec_b[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign digit_ok[gi]       = (load_bcd[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    // With all digits valid, unsigned ordering of BCD words equals decimal ordering.
    generate
        if (MIN_VALUE == 0) begin : g_min_zero
            assign above_min = 1'b1;
        end else begin : g_min_cmp
            assign above_min = (load_bcd >= MIN_BCD);
        end
    endgenerate

    assign load_ok = (&digit_ok) && above_min && (load_bcd <= MAX_BCD);
    assign up      = (CEN | INC) & ~DEC;
    assign dn      = DEC & ~(CEN | INC);
    assign at_max  = (count_q == MAX_BCD);
    assign at_min  = (count_q == MIN_BCD);

    assign carry_out  = n_rst & ~LOAD & up & at_max;
    assign borrow_out = n_rst & ~LOAD & dn & at_min;

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                count_d = load_bcd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (up) begin
            count_d = at_max ? MIN_BCD : inc_val;
        end else if (dn) begin
            count_d = at_min ? MAX_BCD : dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q    <= MIN_BCD;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count_bcd = count_q;
    assign load_err  = load_err_q;
endmodule

// File: tb/tb_bcd_range_counter.sv
// Directed bench for bcd_range_counter: integer reference model feeds a scoreboard
// queue of expected counts; carry/borrow are checked combinationally before each edge.
module tb_bcd_range_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 00..23
    logic       a_n_rst = 1'b0, a_cen = 1'b0, a_inc = 1'b0, a_dec = 1'b0, a_load = 1'b0;
    logic [7:0] a_ld = 8'h00, a_count;
    logic       a_carry, a_borrow, a_err;
    // Instance B: 01..12
    logic       b_n_rst = 1'b0, b_cen = 1'b0, b_inc = 1'b0, b_dec = 1'b0, b_load = 1'b0;
    logic [7:0] b_ld = 8'h00, b_count;
    logic       b_carry, b_borrow, b_err;
    // Cascade: 00..59 feeding 00..23
    logic       c_n_rst = 1'b0, c_cen = 1'b0, c_load = 1'b0;
    logic [7:0] c_lo_ld = 8'h00, c_hi_ld = 8'h00, c_lo_count, c_hi_count;
    logic       c_lo_carry, c_lo_borrow, c_lo_err, c_hi_carry, c_hi_borrow, c_hi_err;

    bcd_range_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(23)) dut_a (
        .clk(clk), .n_rst(a_n_rst), .CEN(a_cen), .INC(a_inc), .DEC(a_dec), .LOAD(a_load),
        .load_bcd(a_ld), .count_bcd(a_count), .carry_out(a_carry), .borrow_out(a_borrow),
        .load_err(a_err));

    bcd_range_counter #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(12)) dut_b (
        .clk(clk), .n_rst(b_n_rst), .CEN(b_cen), .INC(b_inc), .DEC(b_dec), .LOAD(b_load),
        .load_bcd(b_ld), .count_bcd(b_count), .carry_out(b_carry), .borrow_out(b_borrow),
        .load_err(b_err));

    bcd_range_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(59)) dut_lo (
        .clk(clk), .n_rst(c_n_rst), .CEN(c_cen), .INC(1'b0), .DEC(1'b0), .LOAD(c_load),
        .load_bcd(c_lo_ld), .count_bcd(c_lo_count), .carry_out(c_lo_carry),
        .borrow_out(c_lo_borrow), .load_err(c_lo_err));

    bcd_range_counter #(.DIGITS(2), .MIN_VALUE(0), .MAX_VALUE(23)) dut_hi (
        .clk(clk), .n_rst(c_n_rst), .CEN(c_lo_carry), .INC(1'b0), .DEC(1'b0), .LOAD(c_load),
        .load_bcd(c_hi_ld), .count_bcd(c_hi_count), .carry_out(c_hi_carry),
        .borrow_out(c_hi_borrow), .load_err(c_hi_err));

    typedef struct {
        string      tag;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   mval[2] = '{0, 1};
    int   mmin[2] = '{0, 1};
    int   mmax[2] = '{23, 12};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Reference behaviour in plain decimal integers.
    task automatic model(input int sel, input bit rst_n, cen, inc, dec, load,
                         input logic [7:0] ld, output int nv, output bit ec, eb, ee);
        int  v, dval;
        bit  up, dn, ok;
        logic [3:0] dh, dl;
        v  = mval[sel];
        nv = v; ec = 0; eb = 0; ee = 0;
        up = (cen | inc) & ~dec;
        dn = dec & ~(cen | inc);
        dh = ld[7:4];
        dl = ld[3:0];
        dval = int'(dh) * 10 + int'(dl);
        ok = (dh <= 9) && (dl <= 9) && (dval >= mmin[sel]) && (dval <= mmax[sel]);
        if (!rst_n) begin
            nv = mmin[sel];
        end else if (load) begin
            if (ok) nv = dval;
            else    ee = 1;
        end else if (up) begin
            if (v == mmax[sel]) begin nv = mmin[sel]; ec = 1; end
            else nv = v + 1;
        end else if (dn) begin
            if (v == mmin[sel]) begin nv = mmax[sel]; eb = 1; end
            else nv = v - 1;
        end
    endtask

    task automatic cycle(input int sel, input bit rst_n, cen, inc, dec, load,
                         input logic [7:0] ld, input string tag);
        int   nv;
        bit   ec, eb, ee;
        exp_t e;
        @(negedge clk);
        a_n_rst = 1; a_cen = 0; a_inc = 0; a_dec = 0; a_load = 0; a_ld = 8'h00;
        b_n_rst = 1; b_cen = 0; b_inc = 0; b_dec = 0; b_load = 0; b_ld = 8'h00;
        if (sel == 0) begin
            a_n_rst = rst_n; a_cen = cen; a_inc = inc; a_dec = dec; a_load = load; a_ld = ld;
        end else begin
            b_n_rst = rst_n; b_cen = cen; b_inc = inc; b_dec = dec; b_load = load; b_ld = ld;
        end
        #1;
        model(sel, rst_n, cen, inc, dec, load, ld, nv, ec, eb, ee);
        chk({tag, ".carry"},  32'((sel == 0) ? a_carry  : b_carry),  32'(ec));
        chk({tag, ".borrow"}, 32'((sel == 0) ? a_borrow : b_borrow), 32'(eb));
        e.tag = tag; e.cnt = to_bcd(nv); e.err = ee;
        sb.push_back(e);
        mval[sel] = nv;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".count"}, 32'((sel == 0) ? a_count : b_count), 32'(e.cnt));
        chk({e.tag, ".load_err"}, 32'((sel == 0) ? a_err : b_err), 32'(e.err));
        $display("txn %s dut=%0d count=%02h load_err=%0b", e.tag, sel,
                 (sel == 0) ? a_count : b_count, (sel == 0) ? a_err : b_err);
    endtask

    initial begin
        // Instance A: reset then a full wrap of 24 CEN cycles.
        cycle(0, 0, 0, 0, 0, 0, 8'h00, "a_reset");
        for (int i = 0; i < 24; i++) cycle(0, 1, 1, 0, 0, 0, 8'h00, "a_cen_run");
        // Load validation.
        cycle(0, 1, 0, 0, 0, 1, 8'h59, "a_load59_bad");
        cycle(0, 1, 0, 0, 0, 1, 8'h1A, "a_load1A_bad");
        cycle(0, 1, 0, 0, 0, 1, 8'h17, "a_load17_ok");
        cycle(0, 1, 0, 0, 0, 1, 8'h24, "a_load24_bad");
        cycle(0, 1, 0, 0, 0, 0, 8'h00, "a_err_clear");
        // Conflicting requests hold.
        cycle(0, 1, 0, 0, 0, 1, 8'h05, "a_load05");
        cycle(0, 1, 0, 1, 1, 0, 8'h00, "a_inc_dec_hold");
        cycle(0, 1, 1, 0, 1, 0, 8'h00, "a_cen_dec_hold");
        // Down stepping with digit borrow and MIN wrap.
        cycle(0, 1, 0, 0, 0, 1, 8'h10, "a_load10");
        cycle(0, 1, 0, 0, 1, 0, 8'h00, "a_dec_10_09");
        cycle(0, 1, 0, 0, 0, 1, 8'h00, "a_load00");
        cycle(0, 1, 0, 0, 1, 0, 8'h00, "a_dec_wrap");
        // LOAD beats a CEN step at MAX.
        cycle(0, 1, 1, 0, 0, 1, 8'h10, "a_load_over_cen");
        cycle(0, 1, 0, 0, 0, 1, 8'h23, "a_load23");
        cycle(0, 1, 1, 0, 0, 0, 8'h00, "a_inc_wrap");
        // Reset overrides stepping, carry and load errors.
        cycle(0, 1, 0, 0, 0, 1, 8'h15, "a_load15");
        cycle(0, 0, 1, 0, 0, 0, 8'h00, "a_reset_mid");
        cycle(0, 1, 0, 0, 0, 1, 8'h23, "a_load23b");
        cycle(0, 0, 1, 0, 0, 0, 8'h00, "a_reset_at_max");
        cycle(0, 0, 0, 0, 0, 1, 8'h59, "a_reset_bad_load");

        // Instance B: 01..12 range.
        cycle(1, 0, 0, 0, 0, 0, 8'h00, "b_reset");
        cycle(1, 1, 0, 0, 1, 0, 8'h00, "b_dec_wrap");
        cycle(1, 1, 0, 1, 0, 0, 8'h00, "b_inc_wrap");
        cycle(1, 1, 0, 0, 0, 1, 8'h00, "b_load00_bad");
        cycle(1, 1, 0, 0, 0, 1, 8'h13, "b_load13_bad");
        cycle(1, 1, 0, 0, 0, 1, 8'h09, "b_load09");
        cycle(1, 1, 0, 1, 0, 0, 8'h00, "b_inc_09_10");
        cycle(1, 1, 0, 0, 0, 1, 8'h12, "b_load12");
        cycle(1, 1, 0, 0, 1, 0, 8'h00, "b_dec_12_11");

        // Cascade: both stages wrap on one CEN.
        @(negedge clk);
        c_n_rst = 0;
        @(posedge clk); #1;
        chk("c_reset.lo", 32'(c_lo_count), 32'h00);
        chk("c_reset.hi", 32'(c_hi_count), 32'h00);
        @(negedge clk);
        c_n_rst = 1; c_load = 1; c_lo_ld = 8'h59; c_hi_ld = 8'h23;
        @(posedge clk); #1;
        chk("c_load.lo", 32'(c_lo_count), 32'h59);
        chk("c_load.hi", 32'(c_hi_count), 32'h23);
        $display("txn c_load lo=%02h hi=%02h", c_lo_count, c_hi_count);
        @(negedge clk);
        c_load = 0; c_cen = 1;
        #1;
        chk("c_step.lo_carry", 32'(c_lo_carry), 32'h1);
        chk("c_step.hi_carry", 32'(c_hi_carry), 32'h1);
        @(posedge clk); #1;
        chk("c_step.lo", 32'(c_lo_count), 32'h00);
        chk("c_step.hi", 32'(c_hi_count), 32'h00);
        $display("txn c_step lo=%02h hi=%02h", c_lo_count, c_hi_count);
        @(negedge clk);
        c_cen = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
